// File: rtl/trig_capture_frame.sv
// Triggered multi-channel capture buffer: pre-trigger fill, trigger-anchored post
// capture into a circular buffer, then frozen frame readout channel by channel.
module trig_capture_frame #(
  parameter int SAMPLE_WIDTH = 12,
  parameter int NUM_CH       = 2,
  parameter int ADDR_WIDTH   = 10,
  parameter int DEPTH        = 1024,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                           i_clk,
  input  logic                           i_RESET_n,
  input  logic                           i_sample_valid,
  input  logic [NUM_CH*SAMPLE_WIDTH-1:0] i_sample_data,
  input  logic                           i_trigger,
  input  logic                           i_arm,
  input  logic                           i_abort,
  input  logic                           i_mode,
  input  logic [ADDR_WIDTH-1:0]          i_pretrig,
  input  logic                           i_rd_en,
  output logic                           o_sample_valid,
  output logic [SAMPLE_WIDTH-1:0]        o_sample_data,
  output logic [CH_W-1:0]                o_sample_ch,
  output logic                           o_sample_last,
  output logic                           o_capture_done,
  output logic                           o_armed
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] A_ONE    = ADDR_WIDTH'(1'b1);
  localparam logic [PW-1:0]         P_ONE    = PW'(1'b1);
  localparam logic [PW-1:0]         DEPTH_W  = PW'(DEPTH);
  localparam logic [CH_W-1:0]       LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0]       C_ONE    = CH_W'(1'b1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_READOUT = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] pre_q, pre_d;
  logic [ADDR_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
  logic [PW-1:0]         post_cnt_q, post_cnt_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] trig_ptr_q, trig_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_start_q, rd_start_d;
  logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [CH_W-1:0]       rd_ch_q, rd_ch_d;

  logic                    out_valid_q, out_valid_d;
  logic [SAMPLE_WIDTH-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]         out_ch_q, out_ch_d;
  logic                    out_last_q, out_last_d;
  logic                    done_q, done_d;
  logic                    armed_q, armed_d;

  logic [SAMPLE_WIDTH-1:0] mem_q [NUM_CH][DEPTH];

  logic                  active_s;
  logic                  wr_en_s;
  logic                  fill_wr_s;
  logic                  trig_hit_s;
  logic                  post_wr_s;
  logic                  rd_fire_s;
  logic                  last_rd_s;
  logic                  rearm_s;
  logic                  enter_rd_s;
  state_t                arm_state_s;
  logic [ADDR_WIDTH-1:0] pre_cnt_inc_s;
  logic [PW-1:0]         post_cnt_inc_s;
  logic [PW-1:0]         post_tgt_s;
  logic [ADDR_WIDTH-1:0] trig_base_s;
  logic [ADDR_WIDTH-1:0] rd_base_s;

  // Abort dominates every qualified event below, so no stray write/read/arm leaks through.
  assign active_s       = (state_q == S_FILL) || (state_q == S_ARMED) || (state_q == S_POST);
  assign wr_en_s        = active_s && i_sample_valid && !i_abort;
  assign fill_wr_s      = (state_q == S_FILL) && i_sample_valid && !i_abort;
  assign trig_hit_s     = (state_q == S_ARMED) && i_trigger && !i_abort;
  assign post_wr_s      = (state_q == S_POST) && i_sample_valid && !i_abort;
  assign rd_fire_s      = (state_q == S_READOUT) && i_rd_en && !i_abort;
  assign last_rd_s      = rd_fire_s && (rd_ch_q == LAST_CH) && (rd_cnt_q == LAST_IDX);
  assign rearm_s        = !i_abort && (((state_q == S_IDLE) && i_arm) || (last_rd_s && i_mode));
  assign enter_rd_s     = (state_d == S_READOUT) && (state_q != S_READOUT);
  assign arm_state_s    = (i_pretrig == '0) ? S_ARMED : S_FILL;
  assign pre_cnt_inc_s  = pre_cnt_q + A_ONE;
  assign post_cnt_inc_s = post_cnt_q + P_ONE;
  assign post_tgt_s     = DEPTH_W - {1'b0, pre_q};
  // Entry into READOUT straight from ARMED uses the pointer being captured this cycle.
  assign trig_base_s    = (state_q == S_ARMED) ? wr_ptr_q : trig_ptr_q;
  assign rd_base_s      = trig_base_s - pre_q;

  // State register.
  always_ff @(posedge i_clk or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (i_abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    state_d = i_arm ? arm_state_s : S_IDLE;
        S_FILL:    state_d = (i_sample_valid && (pre_cnt_inc_s == pre_q)) ? S_ARMED : S_FILL;
        S_ARMED: begin
          if (!i_trigger) begin
            state_d = S_ARMED;
          end else if (i_sample_valid && (post_tgt_s == P_ONE)) begin
            state_d = S_READOUT;
          end else begin
            state_d = S_POST;
          end
        end
        S_POST:    state_d = (i_sample_valid && (post_cnt_inc_s == post_tgt_s)) ? S_READOUT : S_POST;
        S_READOUT: state_d = !last_rd_s ? S_READOUT : (i_mode ? arm_state_s : S_IDLE);
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Capture counters, write pointer and readout addressing.
  always_comb begin
    pre_d      = pre_q;
    pre_cnt_d  = pre_cnt_q;
    post_cnt_d = post_cnt_q;
    trig_ptr_d = trig_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_start_d = rd_start_q;
    rd_cnt_d   = rd_cnt_q;
    rd_ch_d    = rd_ch_q;
    wr_ptr_d   = wr_en_s ? (wr_ptr_q + A_ONE) : wr_ptr_q;

    if (rearm_s) begin
      pre_d      = i_pretrig;
      pre_cnt_d  = '0;
      post_cnt_d = '0;
    end else if (fill_wr_s) begin
      pre_cnt_d  = pre_cnt_inc_s;
    end else if (trig_hit_s) begin
      trig_ptr_d = wr_ptr_q;
      post_cnt_d = i_sample_valid ? P_ONE : '0;
    end else if (post_wr_s) begin
      post_cnt_d = post_cnt_inc_s;
    end else begin
      pre_cnt_d  = pre_cnt_q;
    end

    if (enter_rd_s) begin
      rd_start_d = rd_base_s;
      rd_ptr_d   = rd_base_s;
      rd_cnt_d   = '0;
      rd_ch_d    = '0;
    end else if (rd_fire_s) begin
      if (rd_cnt_q == LAST_IDX) begin
        rd_cnt_d = '0;
        rd_ptr_d = rd_start_q;
        rd_ch_d  = (rd_ch_q == LAST_CH) ? '0 : (rd_ch_q + C_ONE);
      end else begin
        rd_cnt_d = rd_cnt_q + A_ONE;
        rd_ptr_d = rd_ptr_q + A_ONE;
      end
    end else begin
      rd_cnt_d = rd_cnt_q;
    end
  end

  // Registered outputs.
  always_comb begin
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    armed_d     = (state_d == S_ARMED);
    if (i_abort) begin
      done_d = 1'b0;
    end else if (rd_fire_s) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_q[rd_ch_q][rd_ptr_q];
      out_ch_d    = rd_ch_q;
      out_last_d  = last_rd_s;
      done_d      = !last_rd_s;
    end else if (enter_rd_s) begin
      done_d = 1'b1;
    end else begin
      done_d = done_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      pre_q       <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      trig_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      rd_start_q  <= '0;
      rd_cnt_q    <= '0;
      rd_ch_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      trig_ptr_q  <= trig_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_start_q  <= rd_start_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_ch_q     <= rd_ch_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      armed_q     <= armed_d;
    end
  end

  // Sample memory, one bank per channel; contents are not reset.
  always_ff @(posedge i_clk) begin
    if (wr_en_s) begin
      for (int k = 0; k < NUM_CH; k++) begin
        mem_q[k][wr_ptr_q] <= i_sample_data[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      end
    end
  end

  assign o_sample_valid = out_valid_q;
  assign o_sample_data  = out_data_q;
  assign o_sample_ch    = out_ch_q;
  assign o_sample_last  = out_last_q;
  assign o_capture_done = done_q;
  assign o_armed        = armed_q;

endmodule

// File: tb/tb_trig_capture_frame.sv
// Bench for trig_capture_frame: frame-level reference model compared every cycle,
// plus literal expectations for the first/last samples of each frame.
module tb_trig_capture_frame;
  localparam int SW = 12;
  localparam int NC = 2;
  localparam int AW = 4;
  localparam int D  = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic sv, trig, arm, abort_s, mode, rd;
  logic [NC*SW-1:0] sdata;
  logic [AW-1:0] pretrig;
  logic ov, olast, odone, oarmed;
  logic [SW-1:0] odata;
  logic [0:0] och;

  int checks = 0;
  int failures = 0;
  int n = 0;

  always #20 clk = ~clk;

  trig_capture_frame #(
    .SAMPLE_WIDTH(SW), .NUM_CH(NC), .ADDR_WIDTH(AW), .DEPTH(D)
  ) dut (
    .i_clk(clk), .i_RESET_n(rst_n), .i_sample_valid(sv), .i_sample_data(sdata),
    .i_trigger(trig), .i_arm(arm), .i_abort(abort_s), .i_mode(mode),
    .i_pretrig(pretrig), .i_rd_en(rd), .o_sample_valid(ov), .o_sample_data(odata),
    .o_sample_ch(och), .o_sample_last(olast), .o_capture_done(odone), .o_armed(oarmed)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history of samples since arm, trigger index, expected frame queue.
  typedef struct { int data; int ch; bit last; } exp_t;
  exp_t frame_q[$];
  exp_t m_e;
  int h0[$];
  int h1[$];
  int m_phase = 0;
  int m_pre = 0;
  int m_trig = -1;
  bit e_valid = 1'b0, e_last = 1'b0, e_done = 1'b0, e_armed = 1'b0;
  int e_data = 0, e_ch = 0;

  task automatic m_start(input int p);
    m_phase = 1;
    m_pre   = p;
    m_trig  = -1;
    h0.delete();
    h1.delete();
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = 0; m_trig = -1; frame_q.delete();
      e_valid = 1'b0; e_last = 1'b0; e_done = 1'b0; e_armed = 1'b0;
    end else begin
      e_valid = 1'b0;
      e_last  = 1'b0;
      if (abort_s) begin
        m_phase = 0;
        e_done  = 1'b0;
        frame_q.delete();
      end else if (m_phase == 0) begin
        if (arm) m_start(int'(pretrig));
      end else if (m_phase == 1) begin
        if (m_trig < 0 && h0.size() >= m_pre && trig) m_trig = h0.size();
        if (sv) begin
          h0.push_back(int'(sdata[SW-1:0]));
          h1.push_back(int'(sdata[2*SW-1:SW]));
        end
        if (m_trig >= 0 && (h0.size() - m_trig) == (D - m_pre)) begin
          for (int c = 0; c < NC; c++) begin
            for (int i = 0; i < D; i++) begin
              m_e.data = (c == 0) ? h0[m_trig - m_pre + i] : h1[m_trig - m_pre + i];
              m_e.ch   = c;
              m_e.last = (c == NC - 1) && (i == D - 1);
              frame_q.push_back(m_e);
            end
          end
          m_phase = 2;
          e_done  = 1'b1;
        end
      end else begin
        if (rd && frame_q.size() > 0) begin
          m_e = frame_q.pop_front();
          e_valid = 1'b1; e_data = m_e.data; e_ch = m_e.ch; e_last = m_e.last;
          if (m_e.last) begin
            e_done = 1'b0;
            if (mode) m_start(int'(pretrig));
            else m_phase = 0;
          end
        end
      end
      e_armed = (m_phase == 1) && (m_trig < 0) && (h0.size() >= m_pre);
    end
  end

  // Compare process, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("valid", {31'd0, ov}, {31'd0, e_valid});
    chk("last", {31'd0, olast}, {31'd0, e_last});
    chk("done", {31'd0, odone}, {31'd0, e_done});
    chk("armed", {31'd0, oarmed}, {31'd0, e_armed});
    if (e_valid) begin
      chk("data", {20'd0, odata}, e_data);
      chk("ch", {31'd0, och}, e_ch);
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic t);
    sv = 1'b1; trig = t; sdata = {SW'(100 + n), SW'(n)};
    tick();
    n++;
    sv = 1'b0; trig = 1'b0;
  endtask

  task automatic arm_it(input int p, input int n0);
    arm = 1'b1; pretrig = AW'(p);
    tick();
    arm = 1'b0; n = n0;
  endtask

  task automatic read_frame(input int f0, input int f1);
    chk("lit_done_before_read", {31'd0, odone}, 32'd1);
    for (int i = 0; i < 2*D; i++) begin
      rd = 1'b1;
      tick();
      if (i == 0) begin
        chk("lit_first_ch0", {20'd0, odata}, f0);
        chk("lit_first_chan", {31'd0, och}, 32'd0);
      end
      if (i == D) chk("lit_first_ch1", {20'd0, odata}, f1);
      if (i == 2*D - 1) begin
        chk("lit_last_data", {20'd0, odata}, f1 + D - 1);
        chk("lit_last_flag", {31'd0, olast}, 32'd1);
        chk("lit_done_clear", {31'd0, odone}, 32'd0);
      end
    end
    rd = 1'b0;
    tick();
    chk("lit_valid_drop", {31'd0, ov}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; sv = 1'b0; trig = 1'b0; arm = 1'b0; abort_s = 1'b0;
    mode = 1'b0; rd = 1'b0; pretrig = '0; sdata = '0;
    tick(); tick();
    chk("rst_valid", {31'd0, ov}, 32'd0);
    chk("rst_done", {31'd0, odone}, 32'd0);
    chk("rst_armed", {31'd0, oarmed}, 32'd0);
    chk("rst_data", {20'd0, odata}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Ramp capture, pre=4, trigger at sample 20; samples after freeze are dropped.
    arm_it(4, 0);
    for (int k = 0; k < 36; k++) push(k == 20);
    read_frame(16, 116);
    chk("t1_idle_armed", {31'd0, oarmed}, 32'd0);

    // pre=0, trigger while valid low.
    arm_it(0, 50);
    chk("t2_armed_now", {31'd0, oarmed}, 32'd1);
    trig = 1'b1; tick(); trig = 1'b0;
    for (int k = 0; k < 20; k++) push(1'b0);
    read_frame(50, 150);

    // Triggers during the fill holdoff are ignored.
    arm_it(4, 0);
    for (int k = 0; k < 4; k++) begin
      push(1'b1);
      if (k == 2) chk("t3_not_armed", {31'd0, oarmed}, 32'd0);
      if (k == 3) chk("t3_armed", {31'd0, oarmed}, 32'd1);
    end
    for (int k = 4; k < 26; k++) push(k == 10);
    read_frame(6, 106);

    // Auto re-arm.
    mode = 1'b1;
    arm_it(2, 0);
    for (int k = 0; k < 20; k++) push(k == 5);
    pretrig = AW'(3);
    read_frame(3, 103);
    chk("t4_refill_not_armed", {31'd0, oarmed}, 32'd0);
    n = 200;
    for (int k = 0; k < 20; k++) push(k == 4);
    mode = 1'b0;
    read_frame(201, 301);

    // Abort with trigger in ARMED, then abort mid-readout.
    arm_it(2, 0);
    push(1'b0); push(1'b0);
    chk("t5_armed", {31'd0, oarmed}, 32'd1);
    abort_s = 1'b1; trig = 1'b1; sv = 1'b1;
    tick();
    abort_s = 1'b0; trig = 1'b0; sv = 1'b0;
    chk("t5_abort_armed", {31'd0, oarmed}, 32'd0);
    chk("t5_abort_done", {31'd0, odone}, 32'd0);
    rd = 1'b1; repeat (3) tick(); rd = 1'b0;
    chk("t5_idle_rd", {31'd0, ov}, 32'd0);
    arm_it(2, 0);
    for (int k = 0; k < 20; k++) push(k == 5);
    rd = 1'b1; repeat (5) tick();
    chk("t5_reading", {31'd0, ov}, 32'd1);
    abort_s = 1'b1;
    tick();
    abort_s = 1'b0;
    chk("t5_abort_valid", {31'd0, ov}, 32'd0);
    chk("t5_abort_done2", {31'd0, odone}, 32'd0);
    chk("t5_abort_last", {31'd0, olast}, 32'd0);
    repeat (3) tick();
    rd = 1'b0;
    chk("t5_rd_ignored", {31'd0, ov}, 32'd0);

    // Asynchronous reset during POST and during readout.
    arm_it(2, 0);
    for (int k = 0; k < 8; k++) push(k == 5);
    #5 rst_n = 1'b0;
    #2;
    chk("t6_post_rst_done", {31'd0, odone}, 32'd0);
    chk("t6_post_rst_armed", {31'd0, oarmed}, 32'd0);
    tick();
    rst_n = 1'b1;
    arm_it(2, 0);
    for (int k = 0; k < 20; k++) push(k == 5);
    rd = 1'b1; repeat (3) tick(); rd = 1'b0;
    chk("t6_valid_before_rst", {31'd0, ov}, 32'd1);
    #5 rst_n = 1'b0;
    #2;
    chk("t6_rst_valid", {31'd0, ov}, 32'd0);
    chk("t6_rst_done", {31'd0, odone}, 32'd0);
    chk("t6_rst_data", {20'd0, odata}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) push(k % 3 == 0);
    chk("t6_no_arm_done", {31'd0, odone}, 32'd0);
    chk("t6_no_arm_armed", {31'd0, oarmed}, 32'd0);
    arm_it(2, 0);
    for (int k = 0; k < 20; k++) push(k == 5);
    read_frame(3, 103);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/trig_capture_frame.md
TRIG_CAPTURE_FRAME -- requirements
Module: trig_capture_frame

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 12, bits per sample per channel.
REQ-002 SHALL have parameter NUM_CH, default 2, number of captured channels (1..8).
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, per-channel buffer address width.
REQ-004 SHALL have parameter DEPTH, default 1024, samples per channel; DEPTH SHALL equal 2**ADDR_WIDTH.
REQ-005 i_clk  in  1  system clock (25 MHz); single clock domain.
REQ-006 i_RESET_n  in  1  reset, asynchronous, active-low.
REQ-007 i_sample_valid  in  1  one sample per channel present this cycle.
REQ-008 i_sample_data  in  NUM_CH*SAMPLE_WIDTH  channel k at bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH].
REQ-009 i_trigger  in  1  trigger event from trigger generator, level-sampled.
REQ-010 i_arm  in  1  start capture from IDLE.
REQ-011 i_abort  in  1  cancel any activity, return to IDLE.
REQ-012 i_mode  in  1  0 = SINGLE, 1 = NORMAL (auto re-arm).
REQ-013 i_pretrig  in  ADDR_WIDTH  pre-trigger sample count, latched on arm.
REQ-014 i_rd_en  in  1  read request, one sample per asserted cycle.
REQ-015 o_sample_valid  out  1  o_sample_data valid this cycle.
REQ-016 o_sample_data  out  SAMPLE_WIDTH  read-out sample.
REQ-017 o_sample_ch  out  $clog2(NUM_CH) (min 1)  channel of o_sample_data.
REQ-018 o_sample_last  out  1  marks final sample of final channel.
REQ-019 o_capture_done  out  1  frame frozen and available for readout.
REQ-020 o_armed  out  1  high in ARMED state (waiting for trigger).

Function
REQ-021 SHALL implement states IDLE, FILL, ARMED, POST, READOUT; one-hot or encoded is free.
REQ-022 IDLE: i_arm=1 -> latch i_pretrig to pre_q, clear pre/post counters, go FILL; writes ignored.
REQ-023 FILL/ARMED/POST: each cycle with i_sample_valid=1 writes all NUM_CH samples at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-024 FILL: counts written samples; leaves for ARMED in the cycle count reaches pre_q; pre_q=0 -> ARMED directly from IDLE-arm path next cycle; i_trigger ignored in FILL (holdoff).
REQ-025 ARMED: i_trigger=1 -> trig_ptr <= wr_ptr, go POST; a sample written in that same cycle is the first post-trigger sample.
REQ-026 POST: counts written samples from trigger; after DEPTH-pre_q samples go READOUT; writes stop thereafter (buffer frozen).
REQ-027 READOUT entry: rd_ptr <= trig_ptr - pre_q (mod DEPTH), rd_ch <= 0, o_capture_done <= 1.
REQ-028 READOUT: i_rd_en=1 -> next cycle o_sample_valid=1, o_sample_data=mem[rd_ch][rd_ptr], o_sample_ch=rd_ch; read latency exactly 1 cycle; i_rd_en=0 -> o_sample_valid=0 next cycle.
REQ-029 rd_ptr wraps modulo DEPTH; after DEPTH reads of a channel rd_ch increments and rd_ptr reloads start address.
REQ-030 Output read DEPTH of channel NUM_CH-1 SHALL assert o_sample_last with o_sample_valid; same cycle o_capture_done <= 0, state -> FILL if i_mode=1 (re-latch i_pretrig) else IDLE.
REQ-031 i_rd_en outside READOUT SHALL be ignored; o_sample_valid SHALL stay 0.
REQ-032 i_abort=1 in any state -> IDLE next cycle, o_capture_done/o_sample_valid/o_sample_last 0; abort has priority over arm, trigger and read in the same cycle.
REQ-033 i_sample_valid=0 in POST SHALL not advance post count; trigger need not coincide with valid.
REQ-034 o_sample_last, o_sample_valid SHALL be single-cycle per sample; all outputs registered.

Reset
REQ-035 i_RESET_n=0 SHALL immediately force IDLE, wr_ptr=rd_ptr=trig_ptr=0, counters 0, all outputs 0; memory contents undefined.
REQ-036 Reset mid-capture or mid-readout SHALL discard the frame; first activity after release requires i_arm.

Verification
REQ-037 NUM_CH=2, DEPTH=16, pre=4, ramp ch0=n, ch1=100+n, trigger at n=20 -> readout ch0 16..31, then ch1 116..131, last flag on 131.
REQ-038 pre=0, trigger with valid low then ramp -> first read sample is first post-trigger sample, 16 per channel.
REQ-039 Trigger pulses during FILL -> ignored; o_armed rises only after pre samples; later trigger captures correctly.
REQ-040 i_mode=1 -> after o_sample_last, FILL re-entered without i_arm; second frame captured on next trigger.
REQ-041 i_abort asserted with i_trigger in ARMED, and mid-READOUT -> IDLE next cycle, all flags 0, i_rd_en ignored.
REQ-042 i_RESET_n pulsed low during POST -> outputs 0 asynchronously; no capture until i_arm.
